// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one nibble per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
`ifdef SUB_OVERFLOW_EN
  ,output logic             ovf
`endif
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow;

   logic [4:0]       sum5;
   logic             borrow_next;
   logic [WIDTH+3:0] diff_cat;
   logic [WIDTH-1:0] diff_next;

`ifdef SUB_OVERFLOW_EN
   logic             a_msb;
   logic             b_msb;
`endif

   assign in_ready = (state == IDLE);

   // Operands shift right each cycle so the active nibble is always bits [3:0];
   // result nibbles enter diff from the top and land in place after NIB steps.
   always_comb begin
      sum5        = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, ~borrow};
      borrow_next = ~sum5[4];
      diff_cat    = {sum5[3:0], diff};
      diff_next   = diff_cat[WIDTH+3:4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         borrow    <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= a;
                  b_q    <= b;
                  borrow <= bin;
                  cnt    <= '0;
                  state  <= CALC;
`ifdef SUB_OVERFLOW_EN
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
`endif
               end
            end
            CALC: begin
               a_q    <= a_q >> 4;
               b_q    <= b_q >> 4;
               borrow <= borrow_next;
               diff   <= diff_next;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  bout      <= borrow_next;
                  zero      <= (diff_next == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef SUB_OVERFLOW_EN
                  ovf       <= (a_msb ^ b_msb) & (diff_next[WIDTH-1] ^ a_msb);
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor at WIDTH=16.
module tb_nibble_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        zero;
`ifdef SUB_OVERFLOW_EN
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero)
`ifdef SUB_OVERFLOW_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts in IDLE at posedge+1 with out_ready=1; ends at posedge+1 back in IDLE.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tbin, input logic [15:0] ed, input logic eb, input logic ez);
      int lat;
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      a = ta;
      b = tb_v;
      bin = tbin;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hDEAD;
      b = 16'hBEEF;
      bin = 1'b1;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_bout"}, bout, eb);
      chk({tag, "_zero"}, zero, ez);
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;
      out_ready = 1'b1;

      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_bout", bout, 0);
      chk("rst_zero", zero, 0);
`ifdef SUB_OVERFLOW_EN
      chk("rst_ovf", ovf, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      run_op("bin_zero", 16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1);
      run_op("eq_zero", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef SUB_OVERFLOW_EN
      chk("eq_zero_ovf", ovf, 0);
      run_op("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0);
      chk("ovf_flag", ovf, 1);
`endif

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 16'h5555;
      b = 16'h1111;
      bin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_diff", diff, 16'h4444);
         chk("bp_bout", bout, 0);
         chk("bp_zero", zero, 0);
         chk("bp_in_ready", in_ready, 0);
         in_valid = (i == 1) || (i == 2);
         a = 16'hFFFF;
         b = 16'h0000;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_drop", out_valid, 0);
      chk("bp_ready_back", in_ready, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("bp_no_ghost_op", out_valid, 0);
      chk("bp_idle", in_ready, 1);

      // Asynchronous reset while nibble 2 is being processed.
      in_valid = 1'b1;
      a = 16'h7777;
      b = 16'h1111;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_diff", diff, 0);
      chk("mid_rst_bout", bout, 0);
      chk("mid_rst_zero", zero, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_no_output", out_valid, 0);
      run_op("after_rst", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);

      // Back-to-back with in_valid held high; operands change during CALC.
      in_valid = 1'b1;
      a = 16'hABCD;
      b = 16'h1111;
      bin = 1'b0;
      @(posedge clk);
      #1;
      a = 16'h0001;
      b = 16'h0002;
      chk("b2b_busy", in_ready, 0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b1_latency", lat, 4);
      chk("b2b1_diff", diff, 16'h9ABC);
      chk("b2b1_bout", bout, 0);
      chk("b2b1_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      chk("b2b1_valid_drop", out_valid, 0);
      chk("b2b_idle", in_ready, 1);
      @(posedge clk);
      #1;
      chk("b2b2_accepted", in_ready, 0);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b2_latency", lat, 4);
      chk("b2b2_diff", diff, 16'hFFFF);
      chk("b2b2_bout", bout, 1);
      chk("b2b2_zero", zero, 0);
      @(posedge clk);
      #1;
      chk("b2b2_valid_drop", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
